// File: rtl/imem_loader_if.sv
// Stream link and instruction-memory write port of the instruction-memory loader.
// The loader connects through the slave modport. The host/memory environment
// connects through the master modport.
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_busy;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wr_data;

    modport master (
        output in_valid, in_data, mem_busy,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_data
    );

    modport slave (
        input  in_valid, in_data, mem_busy,
        output in_ready, mem_wr_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// Takes framed bytes and assembles 16-bit instruction words from them.
// The frame is: 0xA5, LEN_HI, LEN_LO, then LEN words, each sent high byte first.
// The words are written starting at BASE_ADDR.
// The processor is held in reset until a frame loads without error.
// Optional build macro LOADER_CKSUM_EN adds a trailing XOR checksum byte to the frame.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    imem_loader_if.slave       bus,
    output logic               proc_hold,
    output logic               done,
    output logic               err
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);
    localparam logic [7:0]        START   = 8'hA5;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        DONE    = 4'd6,
        ERROR   = 4'd7
`ifdef LOADER_CKSUM_EN
        ,
        CKSUM   = 4'd8
`endif
    } state_t;

    state_t            state_reg;
    logic [15:0]       len_reg;
    logic [15:0]       idx_reg;
    logic [7:0]        hi_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              in_ready_reg;
    logic              mem_wr_en_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [15:0]       mem_wr_data_reg;
    logic              proc_hold_reg;
    logic              done_reg;
    logic              err_reg;
`ifdef LOADER_CKSUM_EN
    logic [7:0]        cksum_reg;
`endif

    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = bus.in_valid & in_ready_reg;
    assign len_full = {len_reg[15:8], bus.in_data};

    assign bus.in_ready    = in_ready_reg;
    assign bus.mem_wr_en   = mem_wr_en_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wr_data = mem_wr_data_reg;
    assign proc_hold       = proc_hold_reg;
    assign done            = done_reg;
    assign err             = err_reg;

    // Frame parser and write sequencer; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            idx_reg         <= '0;
            hi_reg          <= '0;
            addr_reg        <= BASE;
            in_ready_reg    <= 1'b1;
            mem_wr_en_reg   <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= '0;
            proc_hold_reg   <= 1'b1;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
`ifdef LOADER_CKSUM_EN
            cksum_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                // A start byte begins a new load. Any other byte is discarded.
                IDLE, DONE: begin
                    if (xfer && bus.in_data == START) begin
                        state_reg     <= LEN_HI;
                        proc_hold_reg <= 1'b1;
                        done_reg      <= 1'b0;
                        idx_reg       <= '0;
                        addr_reg      <= BASE;
`ifdef LOADER_CKSUM_EN
                        cksum_reg     <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_reg[15:8] <= bus.in_data;
                        state_reg     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_reg <= len_full;
                        if ({1'b0, len_full} > MAX_LEN) begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end else if (len_full == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                            state_reg     <= CKSUM;
`else
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            proc_hold_reg <= 1'b0;
`endif
                        end else begin
                            state_reg <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_reg    <= bus.in_data;
                        state_reg <= DATA_LO;
`ifdef LOADER_CKSUM_EN
                        cksum_reg <= cksum_reg ^ bus.in_data;
`endif
                    end
                end
                // The completed word is presented to memory. The link is stalled until the write commits.
                DATA_LO: begin
                    if (xfer) begin
                        mem_wr_en_reg   <= 1'b1;
                        mem_addr_reg    <= addr_reg;
                        mem_wr_data_reg <= {hi_reg, bus.in_data};
                        in_ready_reg    <= 1'b0;
                        state_reg       <= WRITE;
`ifdef LOADER_CKSUM_EN
                        cksum_reg       <= cksum_reg ^ bus.in_data;
`endif
                    end
                end
                // The write is held stable while memory is busy. It commits on the first free cycle.
                WRITE: begin
                    if (!bus.mem_busy) begin
                        mem_wr_en_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        idx_reg       <= idx_reg + 16'd1;
                        addr_reg      <= addr_reg + 1'b1;
                        if (idx_reg + 16'd1 < len_reg) begin
                            state_reg <= DATA_HI;
                        end else begin
`ifdef LOADER_CKSUM_EN
                            state_reg     <= CKSUM;
`else
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            proc_hold_reg <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LOADER_CKSUM_EN
                CKSUM: begin
                    if (xfer) begin
                        if (bus.in_data == cksum_reg) begin
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            proc_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
`endif
                // Sticky error state. Every byte is dropped until reset.
                ERROR: begin
                    err_reg       <= 1'b1;
                    proc_hold_reg <= 1'b1;
                    done_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader.
// Two instances are driven by the same stimulus: one with base address 0 and one with base address 0xFFFF.
// Frames are scored against a frame-level reference model of the expected writes and final status.
module tb_imem_loader;

    localparam int MAXW = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(16)) bus0 ();
    imem_loader_if #(.ADDR_W(16)) bus1 ();

    logic hold0, done0, err0;
    logic hold1, done1, err1;

    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_data  = bus0.in_data;
    assign bus1.mem_busy = bus0.mem_busy;

    imem_loader #(.ADDR_W(16), .BASE_ADDR(0), .MAX_WORDS(MAXW)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .proc_hold (hold0),
        .done      (done0),
        .err       (err0)
    );

    imem_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF), .MAX_WORDS(MAXW)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .proc_hold (hold1),
        .done      (done1),
        .err       (err1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Environment state
    logic [31:0] wq0[$], wq1[$], exp0[$], exp1[$];
    logic [15:0] frame_words[$];
    bit          model_err;
    bit          busy_rand = 1'b0;
    int          hold_busy = 0;
    int          wr_en_cycles = 0;
    logic        prev_en, prev_busy;
    logic [15:0] prev_addr, prev_data;

    // Memory side: drive mem_busy, log commits, and check that writes stay stable while stalled
    always @(negedge clk) begin
        if (!rst) begin
            bus0.mem_busy = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (hold_busy > 0 && bus0.mem_wr_en) begin
                bus0.mem_busy = 1'b1;
                hold_busy--;
            end else begin
                bus0.mem_busy = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            if (bus0.mem_wr_en) begin
                wr_en_cycles++;
                chk("rdy_in_write", {31'd0, bus0.in_ready}, 32'd0);
                if (prev_en && prev_busy) begin
                    chk("hold_addr", {16'd0, bus0.mem_addr}, {16'd0, prev_addr});
                    chk("hold_data", {16'd0, bus0.mem_wr_data}, {16'd0, prev_data});
                end
                if (!bus0.mem_busy) wq0.push_back({bus0.mem_addr, bus0.mem_wr_data});
            end
            if (bus1.mem_wr_en && !bus0.mem_busy) wq1.push_back({bus1.mem_addr, bus1.mem_wr_data});
            prev_en   = bus0.mem_wr_en;
            prev_busy = bus0.mem_busy;
            prev_addr = bus0.mem_addr;
            prev_data = bus0.mem_wr_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (busy_rand && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_data  = b;
        n = 0;
        while (!bus0.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus0.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, bus0.mem_wr_en}, 32'd0);
        chk("rst_addr0", {16'd0, bus0.mem_addr}, 32'd0);
        chk("rst_addr1", {16'd0, bus1.mem_addr}, 32'd0);
        chk("rst_data", {16'd0, bus0.mem_wr_data}, 32'd0);
        chk("rst_hold", {31'd0, hold0}, 32'd1);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_err = 1'b0;
    endtask

    // Send one frame built from frame_words and score it against the frame-level model
    task automatic run_frame(input logic [15:0] len, input bit bad_ck);
        logic [7:0] ck;
        bit big, ok;
        int n;
        big = (int'(len) > MAXW);
`ifdef LOADER_CKSUM_EN
        ok = !model_err && !big && !bad_ck;
`else
        ok = !model_err && !big;
`endif
        exp0.delete(); exp1.delete(); wq0.delete(); wq1.delete();
        if (!model_err && !big) begin
            for (int i = 0; i < int'(len); i++) begin
                exp0.push_back({16'(i), frame_words[i]});
                exp1.push_back({16'(32'hFFFF + i), frame_words[i]});
            end
        end
        ck = 8'h00;
        send_byte(8'hA5);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        if (big) begin
            // A new start attempt must be ignored once in error
            send_byte(8'hA5);
            send_byte(8'h00);
            send_byte(8'h01);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                send_byte(frame_words[i][15:8]);
                send_byte(frame_words[i][7:0]);
                ck = ck ^ frame_words[i][15:8] ^ frame_words[i][7:0];
            end
`ifdef LOADER_CKSUM_EN
            if (bad_ck) send_byte((ck == 8'h00) ? 8'hFF : 8'h00);
            else        send_byte(ck);
`endif
        end
        n = 0;
        while ((bus0.mem_wr_en || bus1.mem_wr_en) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("settle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        chk("wr_cnt0", 32'(wq0.size()), 32'(exp0.size()));
        chk("wr_cnt1", 32'(wq1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp0.size() && i < wq0.size(); i++) chk("wr0", wq0[i], exp0[i]);
        for (int i = 0; i < exp1.size() && i < wq1.size(); i++) chk("wr1", wq1[i], exp1[i]);
        chk("done0", {31'd0, done0}, {31'd0, ok});
        chk("hold0", {31'd0, hold0}, {31'd0, !ok});
        chk("err0", {31'd0, err0}, {31'd0, !ok});
        chk("done1", {31'd0, done1}, {31'd0, ok});
        chk("err1", {31'd0, err1}, {31'd0, !ok});
        if (!ok) model_err = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] junk;
        int kind, nj;
        logic [15:0] len;
        bus0.in_valid = 1'b0;
        bus0.in_data  = 8'h00;
        rst = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic two-word load preceded by a stray byte
        send_byte(8'h12);
        frame_words = '{16'h4021, 16'hD80C};
        run_frame(16'd2, 1'b0);

        // Memory busy for four cycles during the first write
        hold_busy = 4;
        wr_en_cycles = 0;
        run_frame(16'd2, 1'b0);
        chk("busy_wr_en_cycles", 32'(wr_en_cycles), 32'd6);

        // Oversized frame, then a valid frame that must be ignored
        frame_words.delete();
        run_frame(16'h0401, 1'b0);
        frame_words = '{16'h1111, 16'h2222};
        run_frame(16'd2, 1'b0);
        do_reset();

`ifdef LOADER_CKSUM_EN
        // Wrong checksum byte
        frame_words = '{16'h4021, 16'hD80C};
        run_frame(16'd2, 1'b1);
        do_reset();
`endif

        // Reset between the high and low data bytes, then a clean reload
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h40);
        do_reset();
        frame_words = '{16'hABCD, 16'h1234};
        run_frame(16'd2, 1'b0);

        // Randomized frames with random stalls
        busy_rand = 1'b1;
        for (int f = 0; f < 25; f++) begin
            if (model_err && $urandom_range(0, 1) == 1) do_reset();
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk);
            end
            kind = $urandom_range(0, 9);
            frame_words.delete();
            if (kind == 0) begin
                len = 16'd0;
            end else if (kind == 1) begin
                len = 16'($urandom_range(MAXW + 1, 65535));
            end else begin
                len = 16'($urandom_range(1, 6));
                for (int i = 0; i < int'(len); i++) frame_words.push_back(16'($urandom));
            end
            run_frame(len, kind == 2);
        end
        busy_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
